// File: rtl/word_framer.sv
// -----------------------------------------------------------------------------
// word_framer
//
// Frames a serial bit stream into WIDTH-bit words. The bits are shifted into an
// upstream shift register whose parallel output arrives on q_in; bit_en marks
// every edge at which q_in already holds one newly shifted bit. After WIDTH
// such edges the whole of q_in is captured into a one-entry output buffer with
// a valid/ready handshake. A completed word that finds the buffer full (and
// not being drained on that edge) is dropped, and the sticky overrun flag is
// set.
//
// Optional feature (macro PATTERN_MATCH_EN): compare each accepted word with
// PATTERN, pulse match for one cycle and count matches in a saturating
// 8-bit counter. Without the macro, match and match_cnt are tied to zero.
//
// Ports
//   clk        in   rising-edge clock, shared with the upstream shift register
//   reset      in   asynchronous, active-high reset
//   bit_en     in   q_in holds one newly shifted bit at this edge
//   q_in       in   [WIDTH] parallel output of the upstream shift register
//   out_ready  in   downstream accepts the buffered word this cycle
//   word       out  [WIDTH] captured word
//   word_valid out  word holds an unconsumed value
//   overrun    out  sticky: a completed word was dropped
//   match      out  one-cycle pulse: accepted word equals PATTERN
//   match_cnt  out  [8] saturating number of matches
// -----------------------------------------------------------------------------
module word_framer #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] PATTERN = 5'b10010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic [WIDTH-1:0] q_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             overrun,
  output logic             match,
  output logic [7:0]       match_cnt
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE    = 1'b0;  // cnt == 0, waiting for bit 0
  localparam logic [0:0] COLLECT = 1'b1;  // cnt in 1..WIDTH-1

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          complete;   // this edge delivers the last bit of a word
  logic          accept;     // the completed word is loaded into the buffer
  logic          consume;    // downstream takes the buffered word

  assign complete = bit_en && (cnt == LAST);
  assign consume  = word_valid && out_ready;
  // The buffer can take a new word if it is empty or drained on this same edge.
  assign accept   = complete && (!word_valid || out_ready);

  // Bit counter and framing FSM. Nothing moves while bit_en is low.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bit_en) begin
      if (complete) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= COLLECT;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  // One-entry output buffer with sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word       <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        word       <= q_in;
        word_valid <= 1'b1;
      end else if (consume) begin
        word_valid <= 1'b0;
      end
      // Completion against a full, undrained buffer: keep the old word.
      if (complete && !accept) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef PATTERN_MATCH_EN
  logic hit;

  // Only accepted words are compared; dropped words never reach the buffer.
  assign hit = accept && (q_in == PATTERN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match     <= 1'b0;
      match_cnt <= 8'd0;
    end else begin
      match <= hit;
      if (hit && (match_cnt != 8'hFF)) begin
        match_cnt <= match_cnt + 8'd1;
      end
    end
  end
`else
  assign match     = 1'b0;
  assign match_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_word_framer.sv
// -----------------------------------------------------------------------------
// tb_word_framer
//
// Self-checking bench for word_framer (WIDTH=5, PATTERN=5'b10010). It models
// the upstream MSB-first shift register and keeps a transaction-level model of
// the framer: a running bit count, a one-entry buffer, a sticky overrun flag
// and a match tally. Expectations for match/match_cnt follow PATTERN_MATCH_EN.
// -----------------------------------------------------------------------------
module tb_word_framer;

  localparam int         W   = 5;
  localparam logic [4:0] PAT = 5'b10010;

  logic         clk = 1'b0;
  logic         reset;
  logic         bit_en;
  logic [W-1:0] q_in;
  logic         out_ready;
  logic [W-1:0] word;
  logic         word_valid;
  logic         overrun;
  logic         match;
  logic [7:0]   match_cnt;

  word_framer #(.WIDTH(W), .PATTERN(PAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .q_in       (q_in),
    .out_ready  (out_ready),
    .word       (word),
    .word_valid (word_valid),
    .overrun    (overrun),
    .match      (match),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] sreg;        // upstream shift register contents
  int           m_nbits;     // bits received towards the current word
  logic [W-1:0] m_word;
  bit           m_valid;
  bit           m_over;
  bit           m_match;
  int           m_cnt;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

`ifdef PATTERN_MATCH_EN
  localparam bit MATCH_ON = 1'b1;
`else
  localparam bit MATCH_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".word"},       32'(word),       32'(m_word));
    check({tag, ".word_valid"}, 32'(word_valid), 32'(m_valid));
    check({tag, ".overrun"},    32'(overrun),    32'(m_over));
    check({tag, ".match"},      32'(match),      32'(m_match));
    check({tag, ".match_cnt"},  32'(match_cnt),  32'(m_cnt));
  endtask

  task automatic model_reset();
    m_nbits = 0;
    m_word  = '0;
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_match = 1'b0;
    m_cnt   = 0;
  endtask

  // Assert reset between edges, check its asynchronous effect, keep it high
  // across one edge with bit_en set (that bit must be ignored), then release.
  task automatic do_reset(input string tag);
    bit_en    = 1'b1;
    q_in      = 5'($urandom);
    out_ready = 1'b0;
    reset     = 1'b1;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset  = 1'b0;
    bit_en = 1'b0;
  endtask

  // One clock cycle: drive inputs, take the edge, update the model, compare.
  task automatic step(input bit be, input bit b, input bit rdy, input string tag);
    logic [W-1:0] qv;
    bit completed;
    bit accepted;
    if (be) begin
      sreg = {sreg[W-2:0], b};
      qv   = sreg;
    end else begin
      qv = 5'($urandom);   // framer must ignore q_in without bit_en
    end
    bit_en    = be;
    q_in      = qv;
    out_ready = rdy;
    @(posedge clk);
    completed = 1'b0;
    if (be) begin
      m_nbits++;
      if (m_nbits == W) begin
        m_nbits   = 0;
        completed = 1'b1;
      end
    end
    accepted = completed && (!m_valid || rdy);
    if (accepted) begin
      m_word  = qv;
      m_valid = 1'b1;
    end else begin
      if (completed) m_over = 1'b1;
      if (m_valid && rdy) m_valid = 1'b0;
    end
    m_match = MATCH_ON && accepted && (qv == PAT);
    if (m_match && m_cnt < 255) m_cnt++;
    #1;
    if (match) pulses++;
    check_all(tag);
  endtask

  logic [9:0] stream10;
  logic [4:0] w2bits;
  logic [4:0] chunk;
  logic [39:0] rbits;

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset     = 1'b0;
    bit_en    = 1'b0;
    q_in      = '0;
    out_ready = 1'b0;
    sreg      = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Two words with a ready downstream: each valid for exactly one cycle.
    stream10 = 10'b1101010010;
    do_reset("rst1");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, stream10[9-i], 1'b1, "ready_stream");
      if (i == 4) begin
        check("w1_value", 32'(word), 32'(5'b11010));
        check("w1_valid", 32'(word_valid), 32'd1);
      end
      if (i == 5) check("w1_one_cycle", 32'(word_valid), 32'd0);
    end
    check("w2_value", 32'(word), 32'(5'b10010));
    check("w2_valid", 32'(word_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1, "ready_drain");
    check("w2_one_cycle", 32'(word_valid), 32'd0);
    check("ready_no_overrun", 32'(overrun), 32'd0);

    // Same stream, downstream never ready: second word is dropped.
    do_reset("rst2");
    for (int i = 0; i < 10; i++) step(1'b1, stream10[9-i], 1'b0, "stall_stream");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "stall_hold");
    check("stall_word", 32'(word), 32'(5'b11010));
    check("stall_valid", 32'(word_valid), 32'd1);
    check("stall_overrun", 32'(overrun), 32'd1);

    // Ready only on the edge that completes word 2: consume and reload.
    do_reset("rst3");
    for (int i = 0; i < 10; i++) step(1'b1, stream10[9-i], (i == 9), "edge_ready");
    check("edge_word", 32'(word), 32'(5'b10010));
    check("edge_valid", 32'(word_valid), 32'd1);
    check("edge_overrun", 32'(overrun), 32'd0);

    // Reset after 3 bits discards the partial word.
    do_reset("rst4");
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, "partial");
    check("partial_no_word", 32'(word_valid), 32'd0);
    do_reset("rst4b");
    w2bits = 5'b10010;
    for (int i = 0; i < 5; i++) step(1'b1, w2bits[4-i], 1'b0, "after_partial");
    check("after_partial_word", 32'(word), 32'(5'b10010));
    check("after_partial_valid", 32'(word_valid), 32'd1);

    // Gaps of 0..3 idle cycles between bits yield the gapless words.
    do_reset("rst5");
    rbits = {$urandom, 8'($urandom)};
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b1, "gap_idle");
      step(1'b1, rbits[39-i], 1'b1, "gap_bit");
      if (i % 5 == 4) begin
        chunk = rbits[39-i +: 5];
        check("gap_word", 32'(word), 32'(chunk));
        check("gap_valid", 32'(word_valid), 32'd1);
      end
    end

    // 300 accepted copies of PATTERN: counter saturates at 255.
    do_reset("rst6");
    pulses = 0;
    for (int k = 0; k < 300; k++)
      for (int i = 0; i < 5; i++) step(1'b1, PAT[4-i], 1'b1, "sat");
    step(1'b0, 1'b0, 1'b1, "sat_tail");
    check("sat_pulses", 32'(pulses), MATCH_ON ? 32'd300 : 32'd0);
    check("sat_count", 32'(match_cnt), MATCH_ON ? 32'd255 : 32'd0);

    // Dropped PATTERN words never count.
    do_reset("rst7");
    pulses = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 5; i++) step(1'b1, PAT[4-i], 1'b0, "drop");
    check("drop_pulses", 32'(pulses), MATCH_ON ? 32'd1 : 32'd0);
    check("drop_overrun", 32'(overrun), 32'd1);

    // Random traffic with a mid-run reset.
    do_reset("rst8");
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) do_reset("rst8b");
      step(1'($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'($urandom),
           1'($urandom_range(0, 3) != 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_framer.md
WORD_FRAMER -- requirements
Module: word_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 5: width of the parallel word taken from the upstream serial-in shift register.
REQ-002 SHALL have parameter PATTERN, default 5'b10010: word value used for pattern matching when PATTERN_MATCH_EN is defined.
REQ-003 SHALL have port clk  input  1  rising-edge clock, shared with the upstream shift register.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bit_en  input  1  high at a clk edge = q_in already holds one newly shifted bit.
REQ-006 SHALL have port q_in  input  WIDTH  parallel output of the upstream shift register.
REQ-007 SHALL have port out_ready  input  1  downstream accepts word this cycle.
REQ-008 SHALL have port word  output  WIDTH  captured word.
REQ-009 SHALL have port word_valid  output  1  word holds an unconsumed value.
REQ-010 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.
REQ-011 SHALL have port match  output  1  one-cycle pulse: captured word equals PATTERN.
REQ-012 SHALL have port match_cnt  output  8  number of matches, saturating.

Function
REQ-013 SHALL keep bit counter cnt in the range 0..WIDTH-1, incremented on each edge with bit_en=1.
REQ-014 SHALL run FSM states IDLE (cnt=0) and COLLECT (cnt 1..WIDTH-1).
REQ-015 SHALL transition IDLE->COLLECT on bit_en and COLLECT->IDLE on the bit_en that completes WIDTH bits; cnt wraps to 0 on that edge.
REQ-016 SHALL hold all state while bit_en=0, with no timeout.
REQ-017 SHALL, on the completing edge, load q_in unmodified (no bit reordering) into word and set word_valid=1 one cycle later (latency 1 clk from the completing edge).
REQ-018 SHALL consume the word when word_valid=1 and out_ready=1 at an edge, clearing word_valid unless a new word completes on the same edge.
REQ-019 SHALL, on simultaneous consume and completion, load the new word with word_valid staying 1 and overrun unchanged.
REQ-020 SHALL, on completion while word_valid=1 and out_ready=0, keep the old word, drop the new one, and set overrun=1 until reset.
REQ-021 SHALL keep word stable while word_valid=1 and out_ready=0.
REQ-022 SHALL ignore out_ready while word_valid=0.

Reset
REQ-023 SHALL, while reset=1, immediately (asynchronously) force cnt=0, state=IDLE, word=0, word_valid=0, overrun=0, match=0, match_cnt=0.
REQ-024 SHALL discard any partially collected word on reset mid-collection; collection restarts at bit 0 after reset deasserts.
REQ-025 SHALL ignore bit_en on the first edge after reset falls only if reset is still high at that edge; otherwise counting starts normally.

Configuration
REQ-026 SHALL provide macro PATTERN_MATCH_EN.
REQ-027 SHALL, with PATTERN_MATCH_EN defined, pulse match for exactly one cycle, coincident with the word_valid rising or reload, for each accepted word equal to PATTERN, and increment match_cnt saturating at 255.
REQ-028 SHALL not generate match or increment match_cnt for dropped (overrun) words.
REQ-029 SHALL, without PATTERN_MATCH_EN, tie match=0 and match_cnt=0 and synthesize no comparator or counter.

Verification
REQ-030 SHALL cover: reset pulse, then bits 1101010010 (q_in = 11010 after bit 5, 10010 after bit 10), out_ready=1 -> word=5'b11010 then 5'b10010, each with a one-cycle word_valid.
REQ-031 SHALL cover: same stream, out_ready=0 throughout -> word stays 5'b11010, word_valid=1, overrun=1 after bit 10.
REQ-032 SHALL cover: out_ready=1 exactly on the edge completing word 2 -> word 1 consumed, word=5'b10010, word_valid=1, overrun=0.
REQ-033 SHALL cover: reset asserted after 3 bits, then 5 more bits 10010 -> first word=5'b10010, no word from the partial bits.
REQ-034 SHALL cover, with PATTERN_MATCH_EN: word 10010 accepted 300 times -> 300 match pulses, match_cnt=255; without the macro -> match=0, match_cnt=0.
REQ-035 SHALL cover: bit_en gaps of 0-3 idle cycles between bits -> words identical to the gapless case.
